mult_div_unit: RTL and testbench

- Iterative multiply/divide unit producing the HI/LO register pair for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Sits in the execute stage. Its HI/LO outputs feed the write-back 3-to-1 result multiplexer, which selects among ALU result, memory data and HI/LO.
- Uses a start/busy/done handshake. The control unit stalls the PC while Busy is high.

---
 rtl/mult_div_unit_pkg.sv | 32 +++
 rtl/mult_div_unit_div_step.sv | 21 ++
 rtl/mult_div_unit.sv | 131 +++++++++++++
 tb/tb_mult_div_unit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mult_div_unit_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_e;

  localparam int NBITS_DEF = 32;

  // Per-operation context captured on an accepted Start.
  typedef struct packed {
    logic is_div;
    logic neg_q;   // sA ^ sB: negate product / quotient
    logic neg_r;   // sA: negate remainder
    logic dz;      // divide with zero divisor
  } ctx_t;

  function automatic int cnt_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/mult_div_unit_div_step.sv
// One restoring-divide iteration: shift in a dividend bit, subtract if it fits.
module mult_div_unit_div_step #(
  parameter int NBits = 32
) (
  input  logic [NBits-1:0] rem,
  input  logic             din,
  input  logic [NBits-1:0] divisor,
  output logic [NBits-1:0] rem_next,
  output logic             q
);

  logic [NBits:0]   trial;
  logic [NBits-1:0] diff;

  assign trial = {rem, din};
  // When the subtract succeeds the true difference is below divisor, so the low bits suffice.
  assign diff     = trial[NBits-1:0] - divisor;
  assign q        = (trial >= {1'b0, divisor});
  assign rem_next = q ? diff : trial[NBits-1:0];

endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit with start/busy/done handshake and MTHI/MTLO.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int NBits = NBITS_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [NBits-1:0] OperandA,
  input  logic [NBits-1:0] OperandB,
  input  logic             HiWrite,
  input  logic             LoWrite,
  input  logic [NBits-1:0] WriteData,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [NBits-1:0] HI,
  output logic [NBits-1:0] LO
);

  localparam int CNT_W = cnt_w(NBits);

  state_e             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [2*NBits-1:0] acc;   // mult: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [NBits-1:0]   opnd;  // multiplicand or divisor magnitude
  ctx_t               ctx;

  logic             is_div_in, sgn_in, sa, sb, last;
  logic [NBits-1:0] mag_a, mag_b;

  assign is_div_in = (Op == OP_DIVU) || (Op == OP_DIV);
  assign sgn_in    = (Op == OP_MULT) || (Op == OP_DIV);
  assign sa        = sgn_in & OperandA[NBits-1];
  assign sb        = sgn_in & OperandB[NBits-1];
  assign mag_a     = sa ? -OperandA : OperandA;
  assign mag_b     = sb ? -OperandB : OperandB;
  assign last      = (cnt == CNT_W'(NBits-1));

  // Shift-add multiply step
  logic [NBits:0]     mul_sum;
  logic [2*NBits-1:0] mul_nxt;
  assign mul_sum = {1'b0, acc[2*NBits-1:NBits]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_nxt = {mul_sum, acc[NBits-1:1]};

  logic [NBits-1:0]   div_rem;
  logic               div_q;
  logic [2*NBits-1:0] div_nxt;

  mult_div_unit_div_step #(.NBits(NBits)) u_div_step (
    .rem      (acc[2*NBits-1:NBits]),
    .din      (acc[NBits-1]),
    .divisor  (opnd),
    .rem_next (div_rem),
    .q        (div_q)
  );
  assign div_nxt = {div_rem, acc[NBits-2:0], div_q};

  // Sign correction; a zero divisor leaves |A| in the remainder, so negating by sA restores raw A.
  logic [2*NBits-1:0] prod;
  logic [NBits-1:0]   fix_hi, fix_lo;
  assign prod = ctx.neg_q ? -acc : acc;

  always_comb begin
    fix_hi = prod[2*NBits-1:NBits];
    fix_lo = prod[NBits-1:0];
    if (ctx.is_div) begin
      fix_hi = ctx.neg_r ? -acc[2*NBits-1:NBits] : acc[2*NBits-1:NBits];
      fix_lo = ctx.dz ? '1 : (ctx.neg_q ? -acc[NBits-1:0] : acc[NBits-1:0]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = FIX;
      FIX:     state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    Busy      = (state == RUN) || (state == FIX);
    Done      = (state == DONE);
    DivByZero = ctx.dz && (state != RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      acc  <= '0;
      opnd <= '0;
      ctx  <= '0;
      HI   <= '0;
      LO   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (HiWrite) HI <= WriteData;
          if (LoWrite) LO <= WriteData;
          if (state == IDLE && Start) begin
            cnt        <= '0;
            ctx.is_div <= is_div_in;
            ctx.neg_q  <= sa ^ sb;
            ctx.neg_r  <= sa;
            ctx.dz     <= is_div_in && (OperandB == '0);
            opnd       <= is_div_in ? mag_b : mag_a;
            acc        <= {{NBits{1'b0}}, (is_div_in ? mag_a : mag_b)};
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          acc <= ctx.is_div ? div_nxt : mul_nxt;
        end
        default: begin
          HI <= fix_hi;
          LO <= fix_lo;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized and directed checks of mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;

  localparam int NB = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          Start, HiWrite, LoWrite;
  logic [1:0]    Op;
  logic [NB-1:0] OperandA, OperandB, WriteData;
  logic          Busy, Done, DivByZero;
  logic [NB-1:0] HI, LO;

  int n_chk = 0;
  int n_err = 0;
  logic [NB-1:0] exp_hi, exp_lo;

  mult_div_unit #(.NBits(NB)) dut (
    .clk(clk), .reset(reset), .Start(Start), .Op(Op),
    .OperandA(OperandA), .OperandB(OperandB),
    .HiWrite(HiWrite), .LoWrite(LoWrite), .WriteData(WriteData),
    .Busy(Busy), .Done(Done), .DivByZero(DivByZero), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [1:0] op, input logic [NB-1:0] a, input logic [NB-1:0] b,
                                output logic [NB-1:0] hi, output logic [NB-1:0] lo, output logic dz);
    logic [63:0] p;
    longint      sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    case (op)
      2'b00: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
      2'b01: begin p = 64'(sa * sb);            hi = p[63:32]; lo = p[31:0]; end
      default: begin
        if (b == 0) begin
          dz = 1'b1; hi = a; lo = '1;
        end else if (op == 2'b10) begin
          hi = a % b; lo = a / b;
        end else begin
          p = 64'(sa / sb); lo = p[31:0];
          p = 64'(sa % sb); hi = p[31:0];
        end
      end
    endcase
  endfunction

  // Issue one op and follow it edge by edge through RUN/FIX/DONE and one cycle beyond.
  task automatic run_op(input logic [1:0] op, input logic [NB-1:0] a, input logic [NB-1:0] b,
                        input bit interfere, input bit mt_same);
    logic [NB-1:0] eh, el;
    logic          edz;
    model(op, a, b, eh, el, edz);
    @(negedge clk);
    Start = 1'b1; Op = op; OperandA = a; OperandB = b;
    if (mt_same) begin
      HiWrite = 1'b1; WriteData = 32'h5A5A_0001; exp_hi = 32'h5A5A_0001;
    end
    @(posedge clk); #1;
    check("busy_e0", Busy, 1'b1);
    check("done_e0", Done, 1'b0);
    check("hi_e0", HI, exp_hi);
    for (int k = 1; k <= NB + 1; k++) begin
      @(negedge clk);
      Start     = interfere && (k == 3);
      HiWrite   = Start;
      WriteData = 32'h1234;
      Op        = 2'($urandom);
      OperandA  = $urandom;
      OperandB  = $urandom;
      @(posedge clk); #1;
      check($sformatf("busy_k%0d", k), Busy, (k <= NB));
      check($sformatf("done_k%0d", k), Done, (k == NB + 1));
      if (k <= NB) begin
        check("hold_hi", HI, exp_hi);
        check("hold_lo", LO, exp_lo);
      end
    end
    exp_hi = eh; exp_lo = el;
    check($sformatf("hi op%0d %h %h", op, a, b), HI, exp_hi);
    check($sformatf("lo op%0d %h %h", op, a, b), LO, exp_lo);
    check("dz", DivByZero, edz);
    // Start during DONE must not launch anything.
    @(negedge clk);
    Start = 1'b1; HiWrite = 1'b0; Op = 2'($urandom);
    @(posedge clk); #1;
    check("done_start_busy", Busy, 1'b0);
    check("done_start_done", Done, 1'b0);
    check("after_hi", HI, exp_hi);
    @(negedge clk);
    Start = 1'b0;
  endtask

  task automatic mt(input bit hw, input bit lw, input logic [NB-1:0] d);
    @(negedge clk);
    HiWrite = hw; LoWrite = lw; WriteData = d;
    if (hw) exp_hi = d;
    if (lw) exp_lo = d;
    @(posedge clk); #1;
    check("mt_hi", HI, exp_hi);
    check("mt_lo", LO, exp_lo);
    @(negedge clk);
    HiWrite = 1'b0; LoWrite = 1'b0;
  endtask

  function automatic logic [NB-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1; Start = 1'b0; Op = '0; OperandA = '0; OperandB = '0;
    HiWrite = 1'b0; LoWrite = 1'b0; WriteData = '0;
    exp_hi = '0; exp_lo = '0;
    #12;
    check("rst_busy", Busy, 1'b0);
    check("rst_done", Done, 1'b0);
    check("rst_dz", DivByZero, 1'b0);
    check("rst_hi", HI, 32'h0);
    check("rst_lo", LO, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    check("multu_ff_hi", HI, 32'hFFFF_FFFE);
    run_op(2'b01, 32'hFFFF_FFFD, 32'd7, 0, 0);
    check("mult_neg_lo", LO, 32'hFFFF_FFEB);
    run_op(2'b11, -32'sd7, 32'd2, 0, 0);
    check("div_neg_lo", LO, 32'hFFFF_FFFD);
    run_op(2'b10, 32'd100, 32'd0, 0, 0);
    check("divu0_flag", DivByZero, 1'b1);
    run_op(2'b10, 32'd100, 32'd7, 0, 0);
    check("divu_q", LO, 32'd14);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    check("div_ovf_lo", LO, 32'h8000_0000);
    run_op(2'b11, -32'sd5, 32'd0, 0, 0);
    run_op(2'b00, 32'd1234, 32'd5678, 1, 0);
    mt(0, 1, 32'hABCD);
    mt(1, 1, 32'h0F0F_0F0F);
    mt(1, 0, 32'h7777);
    run_op(2'b01, 32'd9, 32'hFFFF_FFFE, 0, 1);

    // Async reset in the middle of RUN
    @(negedge clk);
    Start = 1'b1; Op = 2'b00; OperandA = 32'd99; OperandB = 32'd99;
    @(negedge clk);
    Start = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_busy", Busy, 1'b0);
    check("mid_rst_done", Done, 1'b0);
    check("mid_rst_hi", HI, 32'h0);
    check("mid_rst_lo", LO, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
    run_op(2'b00, 32'd6, 32'd7, 0, 0);
    check("multu_42", LO, 32'd42);

    for (int i = 0; i < 40; i++)
      run_op(2'($urandom), pick(), pick(), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
